id_ex_pipe: RTL and testbench

- ID/EX pipeline register for the 5-stage RV32I core; sits directly downstream of the decode control unit.
- Captures the decoded control bundle and the operand/immediate data, then presents them to EX.
- Detects load-use hazards against the instruction currently in EX and inserts a bubble, with a stall request to IF/ID and PC.
- Kills the decode-stage instruction on a flush from branch/jump resolution; keeps saturating bubble and flush counters.

---
 rtl/id_ex_pipe.sv | 125 ++++++++++++
 tb/tb_id_ex_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// rtl/id_ex_pipe.sv - ID/EX pipeline register with load-use bubble insertion and flush kill
module id_ex_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_branch,
  input  logic             id_mr,
  input  logic             id_mwrite,
  input  logic             id_alusrc,
  input  logic             id_regwr,
  input  logic             id_jal,
  input  logic             id_jalr,
  input  logic [1:0]       id_aluop,
  input  logic [1:0]       id_mtoreg,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [3:0]       id_funct,
  input  logic             flush,
  output logic             stall_o,
  output logic             ex_valid,
  output logic             ex_branch,
  output logic             ex_mr,
  output logic             ex_mwrite,
  output logic             ex_alusrc,
  output logic             ex_regwr,
  output logic             ex_jal,
  output logic             ex_jalr,
  output logic [1:0]       ex_aluop,
  output logic [1:0]       ex_mtoreg,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [3:0]       ex_funct,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic use_rs1;
  logic use_rs2;
  logic hazard;

  // rs2 is a real source only for register-register ops, stores and branches
  assign use_rs1 = !id_jal;
  assign use_rs2 = !id_alusrc | id_mwrite | id_branch;
  assign hazard  = id_valid & ex_valid & ex_mr & (ex_rd != 5'd0) &
                   ((use_rs1 & (ex_rd == id_rs1)) | (use_rs2 & (ex_rd == id_rs2)));
  assign stall_o = hazard & !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_mr       <= 1'b0;
      ex_mwrite   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_regwr    <= 1'b0;
      ex_jal      <= 1'b0;
      ex_jalr     <= 1'b0;
      ex_aluop    <= 2'b00;
      ex_mtoreg   <= 2'b00;
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= 5'd0;
      ex_rs2      <= 5'd0;
      ex_rd       <= 5'd0;
      ex_funct    <= 4'd0;
      bubble_cnt  <= '0;
      flush_cnt   <= '0;
    end else if (flush || hazard) begin
      // Bubble: controls cleared, data/index registers hold their last values
      ex_valid  <= 1'b0;
      ex_branch <= 1'b0;
      ex_mr     <= 1'b0;
      ex_mwrite <= 1'b0;
      ex_alusrc <= 1'b0;
      ex_regwr  <= 1'b0;
      ex_jal    <= 1'b0;
      ex_jalr   <= 1'b0;
      ex_aluop  <= 2'b00;
      ex_mtoreg <= 2'b00;
      if (flush) begin
        if (id_valid && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_ONE;
      end else begin
        if (bubble_cnt != CNT_MAX) bubble_cnt <= bubble_cnt + CNT_ONE;
      end
    end else begin
      ex_valid    <= id_valid;
      ex_branch   <= id_branch & id_valid;
      ex_mr       <= id_mr & id_valid;
      ex_mwrite   <= id_mwrite & id_valid;
      ex_alusrc   <= id_alusrc & id_valid;
      ex_regwr    <= id_regwr & id_valid;
      ex_jal      <= id_jal & id_valid;
      ex_jalr     <= id_jalr & id_valid;
      ex_aluop    <= id_valid ? id_aluop : 2'b00;
      ex_mtoreg   <= id_valid ? id_mtoreg : 2'b00;
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// tb/tb_id_ex_pipe.sv - scoreboard bench for id_ex_pipe (CNT_W=2 so saturation is reachable)
module tb_id_ex_pipe;

  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam logic [1:0] CMAX = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid, id_branch, id_mr, id_mwrite, id_alusrc, id_regwr, id_jal, id_jalr;
  logic [1:0] id_aluop, id_mtoreg;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [3:0] id_funct;
  logic flush;
  logic stall_o;
  logic ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr;
  logic [1:0] ex_aluop, ex_mtoreg;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic [3:0] ex_funct;
  logic [CNT_W-1:0] bubble_cnt, flush_cnt;

  id_ex_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_branch(id_branch), .id_mr(id_mr), .id_mwrite(id_mwrite), .id_alusrc(id_alusrc),
    .id_regwr(id_regwr), .id_jal(id_jal), .id_jalr(id_jalr),
    .id_aluop(id_aluop), .id_mtoreg(id_mtoreg),
    .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct(id_funct),
    .flush(flush), .stall_o(stall_o), .ex_valid(ex_valid),
    .ex_branch(ex_branch), .ex_mr(ex_mr), .ex_mwrite(ex_mwrite), .ex_alusrc(ex_alusrc),
    .ex_regwr(ex_regwr), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_aluop(ex_aluop), .ex_mtoreg(ex_mtoreg),
    .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct),
    .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [158:0] exv_t;

  int tests = 0;
  int fails = 0;

  // reference EX-stage state
  logic m_valid, m_branch, m_mr, m_mwrite, m_alusrc, m_regwr, m_jal, m_jalr;
  logic [1:0] m_aluop, m_mtoreg;
  logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0] m_rs1, m_rs2, m_rd;
  logic [3:0] m_funct;
  logic [1:0] m_bub, m_fl;

  exv_t sb_q[$];
  logic [3:0] cnt_q[$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exv_t dut_vec();
    return {ex_valid, ex_branch, ex_mr, ex_mwrite, ex_alusrc, ex_regwr, ex_jal, ex_jalr,
            ex_aluop, ex_mtoreg, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
            ex_rs1, ex_rs2, ex_rd, ex_funct};
  endfunction

  function automatic exv_t model_vec();
    return {m_valid, m_branch, m_mr, m_mwrite, m_alusrc, m_regwr, m_jal, m_jalr,
            m_aluop, m_mtoreg, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_funct};
  endfunction

  task automatic model_reset();
    {m_valid, m_branch, m_mr, m_mwrite, m_alusrc, m_regwr, m_jal, m_jalr} = '0;
    {m_aluop, m_mtoreg, m_pc, m_rs1d, m_rs2d, m_imm, m_rs1, m_rs2, m_rd, m_funct} = '0;
    m_bub = 2'd0;
    m_fl  = 2'd0;
  endtask

  function automatic logic model_hazard();
    logic u1, u2;
    u1 = !id_jal;
    u2 = !id_alusrc || id_mwrite || id_branch;
    return id_valid && m_valid && m_mr && (m_rd != 5'd0) &&
           ((u1 && m_rd == id_rs1) || (u2 && m_rd == id_rs2));
  endfunction

  task automatic model_kill();
    {m_valid, m_branch, m_mr, m_mwrite, m_alusrc, m_regwr, m_jal, m_jalr} = '0;
    m_aluop = 2'b00;
    m_mtoreg = 2'b00;
  endtask

  task automatic model_step();
    if (flush) begin
      model_kill();
      if (id_valid && m_fl != CMAX) m_fl = m_fl + 2'd1;
    end else if (model_hazard()) begin
      model_kill();
      if (m_bub != CMAX) m_bub = m_bub + 2'd1;
    end else begin
      m_valid  = id_valid;
      m_branch = id_branch && id_valid;
      m_mr     = id_mr && id_valid;
      m_mwrite = id_mwrite && id_valid;
      m_alusrc = id_alusrc && id_valid;
      m_regwr  = id_regwr && id_valid;
      m_jal    = id_jal && id_valid;
      m_jalr   = id_jalr && id_valid;
      m_aluop  = id_valid ? id_aluop : 2'b00;
      m_mtoreg = id_valid ? id_mtoreg : 2'b00;
      m_pc = id_pc; m_rs1d = id_rs1_data; m_rs2d = id_rs2_data; m_imm = id_imm;
      m_rs1 = id_rs1; m_rs2 = id_rs2; m_rd = id_rd; m_funct = id_funct;
    end
  endtask

  // Entered just after a negedge with ID inputs applied; returns at the next negedge.
  task automatic cycle(input string tag);
    #1;
    check({tag, "/stall"}, {159'd0, stall_o}, {159'd0, (!flush && model_hazard())});
    model_step();
    sb_q.push_back(model_vec());
    cnt_q.push_back({m_bub, m_fl});
    @(posedge clk);
    #1;
    check({tag, "/ex"}, {1'b0, dut_vec()}, {1'b0, sb_q.pop_front()});
    check({tag, "/cnt"}, {156'd0, bubble_cnt, flush_cnt}, {156'd0, cnt_q.pop_front()});
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic br, input logic mr, input logic mw,
                           input logic as, input logic rw, input logic jl, input logic jr,
                           input logic [1:0] op, input logic [1:0] mt,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    id_valid = v; id_branch = br; id_mr = mr; id_mwrite = mw;
    id_alusrc = as; id_regwr = rw; id_jal = jl; id_jalr = jr;
    id_aluop = op; id_mtoreg = mt;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_funct = 4'($urandom_range(0, 15));
    flush = 1'b0;
  endtask

  task automatic r_add(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    set_instr(1, 0, 0, 0, 0, 1, 0, 0, 2'b10, 2'b01, r1, r2, rd);
  endtask
  task automatic lw(input logic [4:0] r1, input logic [4:0] rd);
    set_instr(1, 0, 1, 0, 1, 1, 0, 0, 2'b00, 2'b00, r1, 5'd0, rd);
  endtask
  task automatic addi(input logic [4:0] r1, input logic [4:0] r2f, input logic [4:0] rd);
    set_instr(1, 0, 0, 0, 1, 1, 0, 0, 2'b10, 2'b01, r1, r2f, rd);
  endtask
  task automatic sw(input logic [4:0] r1, input logic [4:0] r2);
    set_instr(1, 0, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00, r1, r2, 5'd0);
  endtask

  initial begin
    model_reset();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    check("reset/ex", {1'b0, dut_vec()}, {1'b0, model_vec()});
    check("reset/cnt", {156'd0, bubble_cnt, flush_cnt}, 160'd0);
    check("reset/stall", {159'd0, stall_o}, 160'd0);
    rst = 1'b0;

    // pass-through R-type add
    r_add(5'd5, 5'd6, 5'd7);
    id_pc = 32'h100;
    cycle("pass");
    check("pass/pc", {128'd0, ex_pc}, {128'd0, 32'h100});
    check("pass/valid", {159'd0, ex_valid}, 160'd1);

    // load-use: one bubble then capture
    lw(5'd1, 5'd7);           cycle("lu/lw");
    r_add(5'd7, 5'd2, 5'd8);  cycle("lu/bubble");
    check("lu/bubble_valid", {159'd0, ex_valid}, 160'd0);
    cycle("lu/capture");
    check("lu/bcnt", {158'd0, bubble_cnt}, 160'd1);

    // immediate form ignores rs2 field; store uses it
    lw(5'd1, 5'd7);           cycle("imm/lw");
    addi(5'd3, 5'd7, 5'd9);   cycle("imm/addi");
    lw(5'd1, 5'd7);           cycle("st/lw");
    sw(5'd3, 5'd7);           cycle("st/bubble");
    cycle("st/capture");
    check("st/bcnt", {158'd0, bubble_cnt}, 160'd2);

    // x0 never hazards
    lw(5'd1, 5'd0);           cycle("x0/lw");
    r_add(5'd0, 5'd0, 5'd1);  cycle("x0/add");

    // flush beats hazard
    lw(5'd1, 5'd7);           cycle("fl/lw");
    r_add(5'd7, 5'd7, 5'd8);
    flush = 1'b1;             cycle("fl/kill");
    check("fl/fcnt", {158'd0, flush_cnt}, 160'd1);
    check("fl/bcnt", {158'd0, bubble_cnt}, 160'd2);

    // async reset in the middle of a stall
    lw(5'd1, 5'd7);           cycle("rst/lw");
    r_add(5'd7, 5'd2, 5'd8);
    #1;
    check("rst/stall_before", {159'd0, stall_o}, 160'd1);
    rst = 1'b1;
    #1;
    check("rst/ex", {1'b0, dut_vec()}, 160'd0);
    check("rst/cnt", {156'd0, bubble_cnt, flush_cnt}, 160'd0);
    check("rst/stall", {159'd0, stall_o}, 160'd0);
    model_reset();
    rst = 1'b0;
    cycle("rst/after");

    // saturation: five bubbles on a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      lw(5'd1, 5'd7);          cycle("sat/lw");
      r_add(5'd7, 5'd2, 5'd8); cycle("sat/bubble");
    end
    check("sat/bcnt", {158'd0, bubble_cnt}, 160'd3);

    // random mix with small register ranges to provoke hazards
    for (int i = 0; i < 40; i++) begin
      set_instr(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush = ($urandom_range(0, 7) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
